// File: rtl/gp_regfile_pkg.sv
// Shared types and helpers for the 8086-style general-purpose register file:
// width modes, x86 byte-register decode and byte-lane merge.
package gp_regfile_pkg;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } width_mode_e;

  // Widest register the lane-merge helper supports.
  localparam int MAX_W = 64;

  localparam logic [15:0] DEF_SP_RST     = 16'hFFFE;
  localparam int          DEF_STACK_STEP = 2;

  typedef struct packed {
    logic [1:0] idx;
    logic       hi;
  } byte_sel_t;

  // x86 byte code: [1:0] picks AX..BX, [2] picks the high lane (AH..BH).
  function automatic byte_sel_t byte_decode(input logic [2:0] code);
    byte_sel_t sel;
    sel.idx = code[1:0];
    sel.hi  = code[2];
    return sel;
  endfunction

  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_val,
                                                  input logic [MAX_W-1:0] lane_val,
                                                  input logic             hi,
                                                  input int               half);
    logic [MAX_W-1:0] res;
    res = old_val;
    for (int i = 0; i < MAX_W / 2; i++) begin
      if (i < half) begin
        if (hi) res[i + half] = lane_val[i];
        else    res[i]        = lane_val[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gp_regfile_rdport.sv
// One registered read port. It samples the register array's next-state value,
// so a same-cycle write or stack adjust is bypassed into the read.
module gp_regfile_rdport
  import gp_regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] regs_nxt [NUM_REGS],
  input  logic              re,
  input  logic              rword,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int HALF = DATA_W / 2;

  byte_sel_t         rsel;
  logic [DATA_W-1:0] byte_word;
  logic [DATA_W-1:0] read_val;

  always_comb begin
    rsel      = byte_decode(raddr[2:0]);
    byte_word = regs_nxt[AW'(rsel.idx)];
    if (width_mode_e'(rword) == WORD) read_val = regs_nxt[raddr];
    else if (rsel.hi)                 read_val = DATA_W'(byte_word[DATA_W-1:HALF]);
    else                              read_val = DATA_W'(byte_word[HALF-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= read_val;
    end
  end

endmodule

// File: rtl/gp_regfile.sv
// General-purpose register file: word/byte writes, RD_PORTS bypassed read
// ports, and PUSH/POP stack-pointer adjustment with conflict reporting.
module gp_regfile
  import gp_regfile_pkg::*;
#(
  parameter int                 DATA_W     = 16,
  parameter int                 NUM_REGS   = 8,
  parameter int                 RD_PORTS   = 2,
  parameter int                 SP_IDX     = 4,
  parameter int                 STACK_STEP = DEF_STACK_STEP,
  parameter logic [DATA_W-1:0]  SP_RST     = DATA_W'(DEF_SP_RST)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 we,
  input  logic                                 wword,
  input  logic [$clog2(NUM_REGS)-1:0]          waddr,
  input  logic [DATA_W-1:0]                    wdata,
  input  logic [RD_PORTS-1:0]                  re,
  input  logic [RD_PORTS-1:0]                  rword,
  input  logic [RD_PORTS*$clog2(NUM_REGS)-1:0] raddr,
  output logic [RD_PORTS*DATA_W-1:0]           rdata,
  output logic [RD_PORTS-1:0]                  rvalid,
  input  logic                                 push,
  input  logic                                 pop,
  output logic [DATA_W-1:0]                    sp_out,
  output logic                                 stk_err
);

  localparam int                HALF = DATA_W / 2;
  localparam int                AW   = $clog2(NUM_REGS);
  localparam logic [AW-1:0]     SP_A = AW'(SP_IDX);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] regs_nxt [NUM_REGS];
  byte_sel_t         wsel;
  logic [AW-1:0]     wsel_addr;
  logic              is_word;
  logic              sp_written;
  logic              err_nxt;

  always_comb begin
    // NOTE: every combinational output is defaulted first, so no branch can leave it unassigned and infer a latch.
    regs_nxt   = regs;
    wsel       = byte_decode(waddr[2:0]);
    wsel_addr  = AW'(wsel.idx);
    is_word    = (width_mode_e'(wword) == WORD);
    sp_written = we && (is_word ? (waddr == SP_A) : (wsel_addr == SP_A));

    if (we) begin
      if (is_word) regs_nxt[waddr] = wdata;
      else regs_nxt[wsel_addr] = DATA_W'(lane_merge(MAX_W'(regs[wsel_addr]),
                                                    MAX_W'(wdata[HALF-1:0]),
                                                    wsel.hi, HALF));
    end

    // An explicit SP write overrides the adjust; PUSH with POP cancels out.
    if (!sp_written && (push != pop))
      regs_nxt[SP_IDX] = push ? regs[SP_IDX] - STEP : regs[SP_IDX] + STEP;

    err_nxt = (push && pop) || ((push || pop) && sp_written);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is built from flops, so every entry is reset here (an SRAM array could not be).
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == SP_IDX) ? SP_RST : '0;
      stk_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs    <= regs_nxt;
      stk_err <= err_nxt;
    end
  end

  assign sp_out = regs[SP_IDX];

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rdport
    gp_regfile_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
    ) u_rdport (
      .clk      (clk),
      .rst      (rst),
      .regs_nxt (regs_nxt),
      .re       (re[p]),
      .rword    (rword[p]),
      .raddr    (raddr[p*AW +: AW]),
      .rdata    (rdata[p*DATA_W +: DATA_W]),
      .rvalid   (rvalid[p])
    );
  end

endmodule

// File: tb/tb_gp_regfile.sv
// Scoreboard bench for gp_regfile: a default 8x2 instance and a 16-register,
// 3-port instance driven with directed vectors.
module tb_gp_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_we, a_wword, a_push, a_pop, a_stk_err;
  logic [2:0]  a_waddr;
  logic [15:0] a_wdata, a_sp_out;
  logic [1:0]  a_re, a_rword, a_rvalid;
  logic [5:0]  a_raddr;
  logic [31:0] a_rdata;

  logic        b_we, b_wword, b_push, b_pop, b_stk_err;
  logic [3:0]  b_waddr;
  logic [15:0] b_wdata, b_sp_out;
  logic [2:0]  b_re, b_rword, b_rvalid;
  logic [11:0] b_raddr;
  logic [47:0] b_rdata;

  gp_regfile dut_a (
    .clk(clk), .rst(rst), .we(a_we), .wword(a_wword), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .rword(a_rword), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid),
    .push(a_push), .pop(a_pop), .sp_out(a_sp_out), .stk_err(a_stk_err)
  );

  gp_regfile #(.NUM_REGS(16), .RD_PORTS(3)) dut_b (
    .clk(clk), .rst(rst), .we(b_we), .wword(b_wword), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .rword(b_rword), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid),
    .push(b_push), .pop(b_pop), .sp_out(b_sp_out), .stk_err(b_stk_err)
  );

  typedef struct {
    int          key;
    logic [15:0] data;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tag_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor side: pop the oldest expectation for this port and compare.
  task automatic mon_port(input int key, input logic [15:0] d);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].key == key) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_unexpected key%0d: got rvalid=1 data 0x%0h, required no read", key, d);
    end else begin
      check($sformatf("rd#%0d key%0d", sb[idx].tag, key), {16'h0, d}, {16'h0, sb[idx].data});
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) if (a_rvalid[p]) mon_port(p, a_rdata[p*16 +: 16]);
      for (int p = 0; p < 3; p++) if (b_rvalid[p]) mon_port(10 + p, b_rdata[p*16 +: 16]);
    end
  end

  task automatic expect_rd(input int key, input logic [15:0] d);
    exp_t e;
    e.key  = key;
    e.data = d;
    e.tag  = tag_cnt;
    tag_cnt++;
    sb.push_back(e);
  endtask

  task automatic a_wr(input logic word, input logic [2:0] addr, input logic [15:0] d);
    a_we = 1'b1; a_wword = word; a_waddr = addr; a_wdata = d;
  endtask

  task automatic a_rd(input int p, input logic word, input logic [2:0] addr, input logic [15:0] exp);
    a_re[p] = 1'b1; a_rword[p] = word; a_raddr[p*3 +: 3] = addr;
    expect_rd(p, exp);
  endtask

  task automatic b_wr(input logic word, input logic [3:0] addr, input logic [15:0] d);
    b_we = 1'b1; b_wword = word; b_waddr = addr; b_wdata = d;
  endtask

  task automatic b_rd(input int p, input logic word, input logic [3:0] addr, input logic [15:0] exp);
    b_re[p] = 1'b1; b_rword[p] = word; b_raddr[p*4 +: 4] = addr;
    expect_rd(10 + p, exp);
  endtask

  task automatic clear_strobes();
    a_we = 1'b0; a_re = '0; a_push = 1'b0; a_pop = 1'b0;
    b_we = 1'b0; b_re = '0; b_push = 1'b0; b_pop = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    clear_strobes();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_wword = 1'b0; a_waddr = '0; a_wdata = '0; a_rword = '0; a_raddr = '0;
    b_wword = 1'b0; b_waddr = '0; b_wdata = '0; b_rword = '0; b_raddr = '0;
    clear_strobes();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sp_out", {16'h0, a_sp_out}, 32'hFFFE);
    check("rst_rvalid", {30'h0, a_rvalid}, 32'h0);
    check("rst_stk_err", {31'h0, a_stk_err}, 32'h0);
    check("rst_rdata", a_rdata, 32'h0);
    rst = 1'b0;

    // Populate, then reset in the middle of a write while a read is active.
    a_wr(1'b1, 3'd0, 16'h1111); tick();
    a_rd(0, 1'b1, 3'd0, 16'h1111); a_wr(1'b1, 3'd1, 16'h2222); tick();
    a_re[0] = 1'b1; a_rword[0] = 1'b1; a_raddr[2:0] = 3'd0;
    a_wr(1'b1, 3'd2, 16'h3333);
    #2 rst = 1'b1;
    #1;
    check("midrst_rvalid", {30'h0, a_rvalid}, 32'h0);
    check("midrst_sp_out", {16'h0, a_sp_out}, 32'hFFFE);
    check("midrst_rdata", a_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_strobes();
    for (int i = 0; i < 4; i++) begin
      a_rd(0, 1'b1, 3'(2*i),     (2*i == 4)     ? 16'hFFFE : 16'h0000);
      a_rd(1, 1'b1, 3'(2*i + 1), (2*i + 1 == 4) ? 16'hFFFE : 16'h0000);
      tick();
    end

    // Byte lanes.
    a_wr(1'b1, 3'd0, 16'h1234); tick();
    a_wr(1'b0, 3'd4, 16'h00AB); tick();
    a_rd(0, 1'b0, 3'd0, 16'h0034); a_rd(1, 1'b1, 3'd0, 16'hAB34); tick();
    a_rd(0, 1'b0, 3'd4, 16'h00AB); tick();
    tick();
    check("idle_rvalid", {30'h0, a_rvalid}, 32'h0);
    check("idle_rdata_hold", {16'h0, a_rdata[15:0]}, 32'h00AB);

    // Bypass of same-cycle writes (word and byte lanes).
    a_wr(1'b1, 3'd6, 16'h5555); a_rd(0, 1'b1, 3'd6, 16'h5555); a_rd(1, 1'b1, 3'd6, 16'h5555); tick();
    check("bypass_rvalid", {30'h0, a_rvalid}, 32'h3);
    a_wr(1'b0, 3'd1, 16'h0077); a_rd(0, 1'b1, 3'd1, 16'h0077); a_rd(1, 1'b0, 3'd5, 16'h0000); tick();
    a_wr(1'b0, 3'd5, 16'hFF99); a_rd(0, 1'b1, 3'd1, 16'h9977); tick();

    // Stack wrap and consecutive adjusts.
    a_wr(1'b1, 3'd4, 16'h0000); tick();
    check("sp_zero", {16'h0, a_sp_out}, 32'h0000);
    a_push = 1'b1; tick();
    check("push_wrap", {16'h0, a_sp_out}, 32'hFFFE);
    a_pop = 1'b1; tick();
    check("pop_wrap", {16'h0, a_sp_out}, 32'h0000);
    a_wr(1'b1, 3'd4, 16'h1000); tick();
    a_pop = 1'b1; tick();
    check("pop_1000", {16'h0, a_sp_out}, 32'h1002);
    a_push = 1'b1; a_rd(0, 1'b1, 3'd4, 16'h1000); tick();
    check("push_1002", {16'h0, a_sp_out}, 32'h1000);

    // Stack conflicts.
    a_wr(1'b1, 3'd4, 16'h2000); tick();
    a_push = 1'b1; a_pop = 1'b1; tick();
    check("pushpop_sp", {16'h0, a_sp_out}, 32'h2000);
    check("pushpop_err", {31'h0, a_stk_err}, 32'h1);
    tick();
    check("pushpop_err_once", {31'h0, a_stk_err}, 32'h0);
    a_wr(1'b1, 3'd4, 16'h3000); a_push = 1'b1; tick();
    check("wrpush_sp", {16'h0, a_sp_out}, 32'h3000);
    check("wrpush_err", {31'h0, a_stk_err}, 32'h1);
    tick();
    check("wrpush_err_once", {31'h0, a_stk_err}, 32'h0);
    a_wr(1'b0, 3'd4, 16'h00CD); a_push = 1'b1; tick();
    check("bytepush_sp", {16'h0, a_sp_out}, 32'h2FFE);
    check("bytepush_err", {31'h0, a_stk_err}, 32'h0);
    a_rd(0, 1'b1, 3'd0, 16'hCD34); tick();

    // Wider instance: 16 registers, 3 read ports. Byte codes use bits [2:0] only.
    b_wr(1'b1, 4'd12, 16'hBEEF); tick();
    b_wr(1'b1, 4'd0, 16'h1234); tick();
    b_wr(1'b0, 4'd8, 16'h0056); tick();
    b_wr(1'b0, 4'd12, 16'h009A); tick();
    b_rd(0, 1'b1, 4'd12, 16'hBEEF); b_rd(1, 1'b1, 4'd0, 16'h9A56); b_rd(2, 1'b0, 4'd8, 16'h0056); tick();
    check("b_rvalid", {29'h0, b_rvalid}, 32'h7);
    b_rd(0, 1'b0, 4'd12, 16'h009A); b_rd(1, 1'b1, 4'd4, 16'hFFFE); b_rd(2, 1'b1, 4'd8, 16'h0000); tick();
    check("b_sp_out", {16'h0, b_sp_out}, 32'hFFFE);

    tick();
    check("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
